// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bus for uart_tx_arbiter.
// Optional timeout_err signal present when UART_ARB_TIMEOUT_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      tx_done;
  logic [ID_W-1:0]           grant_id;
  logic                      active;
`ifdef UART_ARB_TIMEOUT_EN
  logic                      timeout_err;
`endif

  // Arbiter side
  modport master (
    input  req_valid, req_data, tx_busy, tx_done,
    output req_ready, tx_start, tx_data, grant_id, active
`ifdef UART_ARB_TIMEOUT_EN
    , output timeout_err
`endif
  );

  // Requesters plus transmitter side
  modport slave (
    output req_valid, req_data, tx_busy, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, active
`ifdef UART_ARB_TIMEOUT_EN
    , input timeout_err
`endif
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers. Grants a requester, latches its byte, pulses tx_start, then
// waits for tx_done (plus HOLDOFF idle cycles) before arbitrating again.
// Optional macro UART_ARB_TIMEOUT_EN adds a WAIT-state watchdog (timeout_err).
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int HOLDOFF        = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                reset_n,
  uart_tx_arbiter_if.master  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic [7:0]        gap_cnt;
  logic [DATA_W-1:0] req_bytes [NUM_REQ];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;
`endif

  // Split the flat request data bus into one byte per requester
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Pick the first valid requester after the last served one, wrapping
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((32'(last) + i) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      last          <= ID_W'(NUM_REQ - 1);
      gap_cnt       <= '0;
      bus.req_ready <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= '0;
      bus.grant_id  <= '0;
      bus.active    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt        <= '0;
      bus.timeout_err <= 1'b0;
`endif
    end else begin
      bus.req_ready <= '0;
      bus.tx_start  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      bus.timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (|bus.req_valid && !bus.tx_busy) begin
            bus.grant_id  <= winner;
            bus.req_ready <= NUM_REQ'(1) << winner;
            bus.active    <= 1'b1;
            state         <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A requester that withdrew does not advance the pointer
          if (bus.req_valid[bus.grant_id]) begin
            bus.tx_data  <= req_bytes[bus.grant_id];
            last         <= bus.grant_id;
            bus.tx_start <= 1'b1;
            state        <= S_START;
          end else begin
            bus.active <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_START: begin
`ifdef UART_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.tx_done) begin
            if (HOLDOFF > 0) begin
              gap_cnt <= 8'(HOLDOFF);
              state   <= S_GAP;
            end else begin
              bus.active <= 1'b0;
              state      <= S_IDLE;
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            bus.timeout_err <= 1'b1;
            bus.active      <= 1'b0;
            state           <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt == 8'd1) begin
            bus.active <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          bus.active <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a vector table for the first
// frame plus directed sequences. Instance u0 uses HOLDOFF=0, u1 HOLDOFF=3.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic force_busy;
  logic withhold;
  int   cnt0 = 0;
  int   cnt1 = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) b0 ();
  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) b1 ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLDOFF(0), .TIMEOUT_CYCLES(16)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0.master));
  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLDOFF(3), .TIMEOUT_CYCLES(64)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1.master));

  // Transmitter models: busy for 11 cycles after tx_start, done in the last one
  always @(negedge clk) begin
    if (!reset_n) cnt0 <= 0;
    else if (b0.tx_start) cnt0 <= 11;
    else if (cnt0 > 0) cnt0 <= cnt0 - 1;
    if (!reset_n) cnt1 <= 0;
    else if (b1.tx_start) cnt1 <= 11;
    else if (cnt1 > 0) cnt1 <= cnt1 - 1;
  end

  assign b0.tx_busy = force_busy || (cnt0 != 0);
  assign b0.tx_done = (cnt0 == 1) && !withhold;
  assign b1.tx_busy = (cnt1 != 0);
  assign b1.tx_done = (cnt1 == 1);

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        start;
    logic [7:0]  txd;
    logic [1:0]  gid;
    logic        act;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (b0.req_ready != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_wait: got no req_ready expected a grant within 100 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!b0.active && cnt0 == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_idle: got active=%0b expected idle within 100 cycles", name, b0.active);
    end
  endtask

  // Wait for a grant, check it, check the launch, optionally drop the valid
  task automatic serve(input string name, input logic [1:0] exp_id,
                       input logic [7:0] exp_data, input logic drop);
    logic ok;
    logic [3:0] onehot;
    wait_ready(name, ok);
    if (ok) begin
      onehot = 4'b0001 << exp_id;
      check({name, "_gid"}, 32'(b0.grant_id), 32'(exp_id));
      check({name, "_ready"}, 32'(b0.req_ready), 32'(onehot));
      tick();
      check({name, "_start"}, 32'(b0.tx_start), 32'd1);
      check({name, "_data"}, 32'(b0.tx_data), 32'(exp_data));
      if (drop) b0.req_valid[exp_id] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected $finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;
    int   n;
    int   gap_cycles;
    int   idle_cycles;
    int   busy_grants;

    // First frame: requester 0 alone with 0xAD, expected state cycle by cycle
    vecs[0] = '{4'b0001, 32'h000000AD, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1};
    vecs[1] = '{4'b0001, 32'h000000AD, 4'b0000, 1'b1, 8'hAD, 2'd0, 1'b1};
    for (int k = 2; k < 12; k++) vecs[k] = '{4'b0000, 32'h000000FF, 4'b0000, 1'b0, 8'hAD, 2'd0, 1'b1};
    vecs[12] = '{4'b0000, 32'h000000FF, 4'b0000, 1'b0, 8'hAD, 2'd0, 1'b0};
    vecs[13] = '{4'b0000, 32'h000000FF, 4'b0000, 1'b0, 8'hAD, 2'd0, 1'b0};

    reset_n = 1'b0;
    force_busy = 1'b0;
    withhold = 1'b0;
    b0.req_valid = '0;
    b0.req_data = '0;
    b1.req_valid = '0;
    b1.req_data = '0;
    repeat (3) tick();
    check("rst_ready", 32'(b0.req_ready), 32'd0);
    check("rst_start", 32'(b0.tx_start), 32'd0);
    check("rst_data", 32'(b0.tx_data), 32'd0);
    check("rst_gid", 32'(b0.grant_id), 32'd0);
    check("rst_active", 32'(b0.active), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    check("rst_timeout", 32'(b0.timeout_err), 32'd0);
`endif
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 14; k++) begin
      b0.req_valid = vecs[k].valid;
      b0.req_data = vecs[k].data;
      tick();
      check($sformatf("vec%0d_ready", k), 32'(b0.req_ready), 32'(vecs[k].ready));
      check($sformatf("vec%0d_start", k), 32'(b0.tx_start), 32'(vecs[k].start));
      check($sformatf("vec%0d_txd", k), 32'(b0.tx_data), 32'(vecs[k].txd));
      check($sformatf("vec%0d_gid", k), 32'(b0.grant_id), 32'(vecs[k].gid));
      check($sformatf("vec%0d_active", k), 32'(b0.active), 32'(vecs[k].act));
    end

    // Round robin across all four, then 0 and 2 held continuously
    do_reset();
    b0.req_data = 32'h44332211;
    b0.req_valid = 4'b1111;
    serve("rr0", 2'd0, 8'h11, 1'b1);
    serve("rr1", 2'd1, 8'h22, 1'b1);
    serve("rr2", 2'd2, 8'h33, 1'b1);
    serve("rr3", 2'd3, 8'h44, 1'b1);
    b0.req_valid = 4'b0101;
    serve("alt0", 2'd0, 8'h11, 1'b0);
    serve("alt1", 2'd2, 8'h33, 1'b0);
    serve("alt2", 2'd0, 8'h11, 1'b0);
    serve("alt3", 2'd2, 8'h33, 1'b0);
    b0.req_valid = 4'b0000;
    wait_idle("alt");

    // Requester 1 withdraws in GRANT: no launch, pointer stays at 2
    b0.req_data = 32'h00003C00;
    b0.req_valid = 4'b0010;
    tick();
    check("wd_ready", 32'(b0.req_ready), 32'b0010);
    check("wd_gid", 32'(b0.grant_id), 32'd1);
    b0.req_valid = 4'b0000;
    tick();
    check("wd_start0", 32'(b0.tx_start), 32'd0);
    check("wd_active", 32'(b0.active), 32'd0);
    check("wd_ready_off", 32'(b0.req_ready), 32'd0);
    tick();
    check("wd_start1", 32'(b0.tx_start), 32'd0);
    check("wd_txdata_kept", 32'(b0.tx_data), 32'h33);
    b0.req_data = 32'h002B000B;
    b0.req_valid = 4'b0101;
    serve("wd_next0", 2'd0, 8'h0B, 1'b1);
    serve("wd_next2", 2'd2, 8'h2B, 1'b1);
    wait_idle("wd");

    // Transmitter busy blocks arbitration
    force_busy = 1'b1;
    b0.req_data = 32'hE1000000;
    b0.req_valid = 4'b1000;
    busy_grants = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (b0.req_ready != 4'b0000) busy_grants++;
    end
    check("busy_block", 32'(busy_grants), 32'd0);
    force_busy = 1'b0;
    tick();
    check("busy_release_ready", 32'(b0.req_ready), 32'b1000);
    check("busy_release_gid", 32'(b0.grant_id), 32'd3);
    tick();
    check("busy_start", 32'(b0.tx_start), 32'd1);
    check("busy_data", 32'(b0.tx_data), 32'hE1);
    b0.req_valid = 4'b0000;
    wait_idle("busy");

    // HOLDOFF=3: count GAP cycles between tx_done and the next GRANT
    b1.req_data = 32'h0000BBAA;
    b1.req_valid = 4'b0011;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (b1.req_ready != 4'b0000) begin ok = 1'b1; break; end
    end
    check("ho_first_grant", {31'd0, ok}, 32'd1);
    check("ho_first_gid", 32'(b1.grant_id), 32'd0);
    tick();
    b1.req_valid[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (b1.tx_done) begin ok = 1'b1; break; end
    end
    check("ho_done_seen", {31'd0, ok}, 32'd1);
    gap_cycles = b1.active ? 1 : 0;
    idle_cycles = b1.active ? 0 : 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (b1.req_ready != 4'b0000) break;
      if (b1.active) gap_cycles++;
      else idle_cycles++;
    end
    check("ho_gap_cycles", 32'(gap_cycles), 32'd3);
    check("ho_idle_cycles", 32'(idle_cycles), 32'd1);
    check("ho_grant_latency", 32'(n), 32'd4);
    check("ho_second_gid", 32'(b1.grant_id), 32'd1);
    tick();
    check("ho_second_data", 32'(b1.tx_data), 32'hBB);
    b1.req_valid = 4'b0000;
    repeat (20) tick();

    // Reset during WAIT clears everything asynchronously and restores pointer
    b0.req_data = 32'h0000005A;
    b0.req_valid = 4'b0001;
    serve("rst_pre", 2'd0, 8'h5A, 1'b1);
    repeat (3) tick();
    check("rst_in_wait", 32'(b0.active), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_ready", 32'(b0.req_ready), 32'd0);
    check("arst_start", 32'(b0.tx_start), 32'd0);
    check("arst_data", 32'(b0.tx_data), 32'd0);
    check("arst_gid", 32'(b0.grant_id), 32'd0);
    check("arst_active", 32'(b0.active), 32'd0);
    b0.req_data = 32'h002C000C;
    b0.req_valid = 4'b0101;
    tick();
    reset_n = 1'b1;
    tick();
    check("arst_first_ready", 32'(b0.req_ready), 32'b0001);
    check("arst_first_gid", 32'(b0.grant_id), 32'd0);
    tick();
    check("arst_first_data", 32'(b0.tx_data), 32'h0C);
    b0.req_valid = 4'b0000;
    wait_idle("arst");

`ifdef UART_ARB_TIMEOUT_EN
    // tx_done withheld: watchdog fires 16 cycles into WAIT
    withhold = 1'b1;
    b0.req_data = 32'h00007700;
    b0.req_valid = 4'b0010;
    serve("to_grant", 2'd1, 8'h77, 1'b1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (b0.timeout_err) break;
    end
    check("to_latency", 32'(n), 32'd17);
    check("to_active", 32'(b0.active), 32'd0);
    tick();
    check("to_pulse_end", 32'(b0.timeout_err), 32'd0);
    withhold = 1'b0;
    b0.req_data = 32'h00990000;
    b0.req_valid = 4'b0100;
    serve("to_next", 2'd2, 8'h99, 1'b1);
    wait_idle("to");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
